// File: rtl/ysyx_25030093_pkg.sv
// -----------------------------------------------------------------------------
// ysyx_25030093_pkg
// Shared definitions for the IDU issue stage:
//   - issue_state_e : skid-buffer occupancy encoding (EMPTY / ONE / FULL)
//   - issue_w()     : packed bundle width, SEL_W + 5*DATA_W
//   - FLD_* / fld_lsb() : field positions inside the packed bundle.
//     Packing order (MSB..LSB): alu_single, alu_data1, alu_data2, rs2, csr, pc
// -----------------------------------------------------------------------------
package ysyx_25030093_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } issue_state_e;

    // Field indices; each DATA_W-wide field sits at index*DATA_W,
    // alu_single occupies the top SEL_W bits starting at 5*DATA_W.
    localparam int unsigned FLD_PC  = 32'd0;
    localparam int unsigned FLD_CSR = 32'd1;
    localparam int unsigned FLD_RS2 = 32'd2;
    localparam int unsigned FLD_D2  = 32'd3;
    localparam int unsigned FLD_D1  = 32'd4;
    localparam int unsigned FLD_SEL = 32'd5;

    function automatic int unsigned issue_w(input int unsigned sel_w,
                                            input int unsigned data_w);
        return sel_w + 32'd5 * data_w;
    endfunction

    function automatic int unsigned fld_lsb(input int unsigned fld,
                                            input int unsigned data_w);
        return fld * data_w;
    endfunction

endpackage

// File: rtl/ysyx_25030093_pipe_reg.sv
// -----------------------------------------------------------------------------
// ysyx_25030093_pipe_reg
// Plain W-bit register with load enable and asynchronous active-low clear.
//   clk_i  : clock
//   rst_ni : async reset, active-low, clears q_o to 0
//   ld_i   : load d_i on the rising edge when 1
//   d_i    : next value
//   q_o    : registered value
// -----------------------------------------------------------------------------
module ysyx_25030093_pipe_reg #(
    parameter int unsigned W = 32'd1
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         ld_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    // Storage with load enable; holds value otherwise.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_o <= '0;
        end else if (ld_i) begin
            q_o <= d_i;
        end else begin
            q_o <= q_o;
        end
    end

endmodule

// File: rtl/ysyx_25030093_idu_issue.sv
// -----------------------------------------------------------------------------
// ysyx_25030093_idu_issue
// IDU->EXU issue stage built as a 2-entry skid buffer. in_ready and out_valid
// are registered from next-state, so out_ready never reaches in_ready
// combinationally.
//   clk, rst (async, active-low), flush (sync discard of buffered bundles)
//   in_valid / in_ready / in_* : decode-side bundle handshake
//   out_valid / out_ready / out_* : EXU-side bundle handshake (head = MAIN)
//   issue_cnt : out transfers, stall_cnt : cycles with out_valid & !out_ready
// -----------------------------------------------------------------------------
module ysyx_25030093_idu_issue
    import ysyx_25030093_pkg::*;
#(
    parameter int unsigned DATA_W = 32'd32,
    parameter int unsigned SEL_W  = 32'd5,
    parameter int unsigned CNT_W  = 32'd32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [SEL_W-1:0]  in_alu_single,
    input  logic [DATA_W-1:0] in_alu_data1,
    input  logic [DATA_W-1:0] in_alu_data2,
    input  logic [DATA_W-1:0] in_rs2_data,
    input  logic [DATA_W-1:0] in_csr_data,
    input  logic [DATA_W-1:0] in_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [SEL_W-1:0]  out_alu_single,
    output logic [DATA_W-1:0] out_alu_data1,
    output logic [DATA_W-1:0] out_alu_data2,
    output logic [DATA_W-1:0] out_rs2_data,
    output logic [DATA_W-1:0] out_csr_data,
    output logic [DATA_W-1:0] out_pc,
    output logic [CNT_W-1:0]  issue_cnt,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int unsigned IW      = issue_w(SEL_W, DATA_W);
    localparam int unsigned OFF_PC  = fld_lsb(FLD_PC,  DATA_W);
    localparam int unsigned OFF_CSR = fld_lsb(FLD_CSR, DATA_W);
    localparam int unsigned OFF_RS2 = fld_lsb(FLD_RS2, DATA_W);
    localparam int unsigned OFF_D2  = fld_lsb(FLD_D2,  DATA_W);
    localparam int unsigned OFF_D1  = fld_lsb(FLD_D1,  DATA_W);
    localparam int unsigned OFF_SEL = fld_lsb(FLD_SEL, DATA_W);

    issue_state_e      state_q, state_d;
    logic              out_valid_q, in_ready_q;
    logic [CNT_W-1:0]  issue_cnt_q, stall_cnt_q;

    logic              in_fire_s, out_fire_s;
    logic              main_ld_s, main_from_skid_s, skid_ld_s;
    logic [IW-1:0]     in_bundle_s, main_d_s, main_q_s, skid_q_s;

    assign in_fire_s   = in_valid & in_ready_q;
    assign out_fire_s  = out_valid_q & out_ready;
    assign in_bundle_s = {in_alu_single, in_alu_data1, in_alu_data2,
                          in_rs2_data, in_csr_data, in_pc};
    // FULL drains into MAIN from SKID; every other MAIN load takes the input.
    assign main_d_s    = main_from_skid_s ? skid_q_s : in_bundle_s;

    // Next-state and register-load decode for the skid buffer.
    always_comb begin
        state_d          = state_q;
        main_ld_s        = 1'b0;
        main_from_skid_s = 1'b0;
        skid_ld_s        = 1'b0;
        if (flush) begin
            // Flush wins: any in_fire this cycle is dropped.
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire_s) begin
                        state_d   = ST_ONE;
                        main_ld_s = 1'b1;
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    case ({in_fire_s, out_fire_s})
                        2'b10: begin
                            state_d   = ST_FULL;
                            skid_ld_s = 1'b1;
                        end
                        2'b01: state_d = ST_EMPTY;
                        2'b11: begin
                            state_d   = ST_ONE;
                            main_ld_s = 1'b1;
                        end
                        default: state_d = ST_ONE;
                    endcase
                end
                ST_FULL: begin
                    // in_ready is low here, so no in_fire to consider.
                    if (out_fire_s) begin
                        state_d          = ST_ONE;
                        main_ld_s        = 1'b1;
                        main_from_skid_s = 1'b1;
                    end else begin
                        state_d = ST_FULL;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    // State, registered handshake outputs and performance counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_EMPTY;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            issue_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= (state_d != ST_EMPTY);
            in_ready_q  <= (state_d != ST_FULL);
            // An out_fire coincident with flush was still seen by EXU.
            if (out_fire_s) begin
                issue_cnt_q <= issue_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                issue_cnt_q <= issue_cnt_q;
            end
            if (out_valid_q && !out_ready) begin
                stall_cnt_q <= stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                stall_cnt_q <= stall_cnt_q;
            end
        end
    end

    ysyx_25030093_pipe_reg #(.W(IW)) u_main (
        .clk_i  (clk),
        .rst_ni (rst),
        .ld_i   (main_ld_s),
        .d_i    (main_d_s),
        .q_o    (main_q_s)
    );

    ysyx_25030093_pipe_reg #(.W(IW)) u_skid (
        .clk_i  (clk),
        .rst_ni (rst),
        .ld_i   (skid_ld_s),
        .d_i    (in_bundle_s),
        .q_o    (skid_q_s)
    );

    assign out_valid      = out_valid_q;
    assign in_ready       = in_ready_q;
    assign issue_cnt      = issue_cnt_q;
    assign stall_cnt      = stall_cnt_q;
    assign out_alu_single = main_q_s[OFF_SEL +: SEL_W];
    assign out_alu_data1  = main_q_s[OFF_D1  +: DATA_W];
    assign out_alu_data2  = main_q_s[OFF_D2  +: DATA_W];
    assign out_rs2_data   = main_q_s[OFF_RS2 +: DATA_W];
    assign out_csr_data   = main_q_s[OFF_CSR +: DATA_W];
    assign out_pc         = main_q_s[OFF_PC  +: DATA_W];

endmodule

// File: doc/ysyx_25030093_idu_issue.md
Name: ysyx_25030093_idu_issue

Overview:
- Issue stage on the transmitting side of the IDU→EXU valid/ready handshake.
- Accepts one decoded bundle per cycle from decode: ALU select, two ALU operands, rs2 data, CSR data and PC.
- Presents bundles to EXU in order through a 2-entry skid buffer, so `in_ready` is a registered signal with no combinational path from `out_ready`.
- Provides synchronous flush for redirects, plus issue and stall counters.

Parameters:
- DATA_W, 32, width of alu_data1/alu_data2/rs2_data/csr_data/pc
- SEL_W, 5, width of alu_single
- CNT_W, 32, width of perf counters

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  asynchronous reset, active-low (asserted when 0)
- flush  input  1  synchronous discard of all buffered bundles
- in_valid  input  1  decode bundle valid
- in_ready  output  1  issue stage can accept a bundle (registered)
- in_alu_single  input  SEL_W  ALU operation select
- in_alu_data1  input  DATA_W  ALU operand 1
- in_alu_data2  input  DATA_W  ALU operand 2
- in_rs2_data  input  DATA_W  store/branch rs2 value
- in_csr_data  input  DATA_W  CSR read value
- in_pc  input  DATA_W  instruction PC
- out_valid  output  1  bundle valid toward EXU (registered)
- out_ready  input  1  EXU accepts bundle
- out_alu_single / out_alu_data1 / out_alu_data2 / out_rs2_data / out_csr_data / out_pc  output  as inputs  head bundle
- issue_cnt  output  CNT_W  count of out transfers
- stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0

Behaviour:
- Definitions: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Storage:
  - MAIN register drives the out_* payload.
  - SKID register holds a second bundle.
  - state ∈ {EMPTY, ONE, FULL}.
- Reset (rst=0, async):
  - state=EMPTY, out_valid=0, in_ready=1.
  - All payload registers 0; issue_cnt=0, stall_cnt=0.
  - Reset mid-transfer discards everything; first post-reset cycle behaves as EMPTY.
- Registered outputs:
  - out_valid = (state≠EMPTY).
  - in_ready = (state≠FULL).
  - Both are updated from next-state.
- Transitions when flush=0:
  - EMPTY: in_fire → ONE, MAIN←in.
  - ONE, in_fire & !out_fire → FULL, SKID←in.
  - ONE, !in_fire & out_fire → EMPTY.
  - ONE, in_fire & out_fire → ONE, MAIN←in.
  - ONE, neither → hold.
  - FULL: out_fire → ONE, MAIN←SKID. Otherwise hold. in_fire cannot occur because in_ready=0.
- Ordering: strict FIFO; no bundle is duplicated or dropped absent flush.
- Latency: a bundle accepted in cycle N appears on out_* with out_valid=1 in cycle N+1 at minimum.
- Throughput: 1 bundle/cycle sustained while out_ready=1.
- Payload stability: out_* payload is stable while out_valid=1 and out_ready=0.
- Flush (synchronous, highest priority):
  - Next state=EMPTY, out_valid←0, in_ready←1.
  - An in_fire in the flush cycle is discarded.
  - An out_fire in the flush cycle counts as delivered: EXU has seen it, and issue_cnt increments.
  - Payload registers need not clear.
- Counters:
  - issue_cnt += 1 on out_fire.
  - stall_cnt += 1 when out_valid & !out_ready.
  - Both wrap modulo 2^CNT_W with no saturation.
  - Counters are unaffected by flush.
- Data path: no arithmetic on payload; fields pass through bit-exact.

Decomposition:
- Shared package ysyx_25030093_pkg:
  - state encoding constants ST_EMPTY=2'd0, ST_ONE=2'd1, ST_FULL=2'd2.
  - ISSUE_W = SEL_W + 5*DATA_W, for bundle packing.
  - Field offset constants for the packed bundle.
- One sub-module: ysyx_25030093_pipe_reg.
  - Parameterised-width register with load enable and async active-low reset to 0.
  - Instantiated twice (MAIN, SKID) on the packed bundle.
- The FSM, handshake and counters live in the top.

Test Plan:
- Reset then idle: after rst deasserts, out_valid=0, in_ready=1, issue_cnt=0. Send one bundle (pc=0x80000000, alu_single=5'd3) with out_ready=1 → out_valid=1 next cycle with identical fields, issue_cnt=1.
- Back-pressure: out_ready=0, send pc=0x100 then 0x104 → in_ready=0 after the second accept, stall_cnt increments each cycle. Raise out_ready → 0x100 then 0x104 in order; in_ready returns to 1 one cycle after the first out_fire.
- Streaming: 16 consecutive bundles with in_valid=1 and out_ready=1 → 16 out_fires in 16 consecutive cycles, pc sequence preserved, issue_cnt=16.
- Simultaneous in/out in ONE state: in_fire and out_fire in the same cycle → state stays ONE and out_* shows the new bundle next cycle.
- Flush in FULL with in_valid=1: next cycle out_valid=0 and in_ready=1; the flushed pcs never appear. A bundle sent afterwards appears normally.
- Async reset mid-stream: pulse rst low between clock edges while FULL → out_valid=0 immediately, counters 0, no stale bundle emitted after release.
